// File: rtl/alu_operand_loader.sv
// -----------------------------------------------------------------------------
// alu_operand_loader
//
// Purpose: collects an ALU operation from four slide switches and one push
// button. The button is synchronized and debounced. Each clean press steps an
// FSM that captures operand A, then operand B, then the opcode, and then shows
// the result (SHOW). A final press returns the FSM to WAIT_A.
//
// Configuration macro: ALU_LOADER_VALID_HOLD_EN
//   defined   : valid is high for the whole time the FSM is in SHOW.
//   undefined : valid is a one-cycle pulse in the first cycle of SHOW.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable cycles needed to accept a new btn level
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports:
//   clk   in   system clock, all state updates on posedge
//   rst_n in   asynchronous active-low reset
//   sw    in   [3:0] raw switches, asynchronous to clk
//   btn   in   raw push button, active-high, may bounce
//   a     out  [3:0] registered operand A
//   b     out  [3:0] registered operand B
//   op    out  [2:0] registered opcode
//   valid out  a/b/op form a complete operation
//   stage out  [1:0] FSM state (0 WAIT_A, 1 WAIT_B, 2 WAIT_OP, 3 SHOW)
// -----------------------------------------------------------------------------
module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [2:0] op,
    output logic       valid,
    output logic [1:0] stage
);

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        SHOW    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       r_sw_s1;
    logic [3:0]       r_sw_s2;
    logic             r_btn_s1;
    logic             r_btn_s2;
    logic             r_db;
    logic             r_db_d;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    logic [3:0]       r_a;
    logic [3:0]       r_b;
    logic [2:0]       r_op;
    logic             r_valid;
    logic             w_press;

    // Two-flop synchronizers for the asynchronous inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_s1  <= 4'd0;
            r_sw_s2  <= 4'd0;
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
        end else begin
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= btn;
            r_btn_s2 <= r_btn_s1;
        end
    end

    // Debouncer: the counter measures how long the synchronized button has
    // disagreed with the accepted level. Any agreement (a bounce back) restarts
    // it, so only DEBOUNCE_CYCLES consecutive disagreeing cycles flip r_db.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db   <= 1'b0;
            r_db_d <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_db_d <= r_db;
            if (r_btn_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_db  <= ~r_db;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Rising edge of the debounced level only; a held button yields one strobe.
    assign w_press = r_db & ~r_db_d;

    // Operand capture FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_A;
            r_a     <= 4'd0;
            r_b     <= 4'd0;
            r_op    <= 3'd0;
            r_valid <= 1'b0;
        end else begin
`ifndef ALU_LOADER_VALID_HOLD_EN
            // Pulse mode: valid drops after one cycle unless re-armed below.
            r_valid <= 1'b0;
`endif
            if (w_press) begin
                case (r_state)
                    WAIT_A: begin
                        r_a     <= r_sw_s2;
                        r_valid <= 1'b0;
                        r_state <= WAIT_B;
                    end
                    WAIT_B: begin
                        r_b     <= r_sw_s2;
                        r_state <= WAIT_OP;
                    end
                    WAIT_OP: begin
                        r_op    <= r_sw_s2[2:0];
                        r_valid <= 1'b1;
                        r_state <= SHOW;
                    end
                    SHOW: begin
                        r_valid <= 1'b0;
                        r_state <= WAIT_A;
                    end
                    default: begin
                        r_state <= WAIT_A;
                    end
                endcase
            end
        end
    end

    assign a     = r_a;
    assign b     = r_b;
    assign op    = r_op;
    assign valid = r_valid;
    assign stage = r_state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_loader
//
// Self-checking bench for alu_operand_loader with DEBOUNCE_CYCLES=4. A
// behavioural model tracks the operation being assembled (stage, a, b, op)
// and is advanced once per clean button press; DUT outputs are compared after
// each scenario. Honours ALU_LOADER_VALID_HOLD_EN to select the valid rule.
// -----------------------------------------------------------------------------
module tb_alu_operand_loader;

    localparam int DB = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic       btn;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       valid;
    logic [1:0] stage;

    int checks;
    int failures;
    int valid_cycles;

    // behavioural reference
    int m_stage;
    int m_a;
    int m_b;
    int m_op;

    alu_operand_loader #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sw   (sw),
        .btn  (btn),
        .a    (a),
        .b    (b),
        .op   (op),
        .valid(valid),
        .stage(stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles in which valid was high, sampled at each rising edge.
    always @(posedge clk) begin
        if (valid === 1'b1) valid_cycles <= valid_cycles + 1;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    function automatic void model_reset();
        m_stage = 0; m_a = 0; m_b = 0; m_op = 0;
    endfunction

    // One accepted press, expressed directly from the operation rules.
    function automatic void model_press(input int swv);
        case (m_stage)
            0: m_a  = swv;
            1: m_b  = swv;
            2: m_op = swv % 8;
            default: ;
        endcase
        m_stage = (m_stage + 1) % 4;
    endfunction

    // Clean press: switches settle first, button held well past debounce, then
    // released long enough for the release to be debounced too.
    task automatic press(input logic [3:0] swv);
        @(negedge clk);
        sw = swv;
        idle(3);
        btn = 1'b1;
        idle(DB + 6);
        btn = 1'b0;
        idle(DB + 6);
        model_press(int'(swv));
    endtask

    task automatic check_regs(input string tag);
        checks++;
        if (a !== 4'(m_a) || b !== 4'(m_b) || op !== 3'(m_op) || stage !== 2'(m_stage)) begin
            failures++;
            $display("FAIL %s: got a=%0d b=%0d op=%0d stage=%0d, expected a=%0d b=%0d op=%0d stage=%0d",
                     tag, a, b, op, stage, m_a, m_b, m_op, m_stage);
        end
    endtask

    task automatic check_valid(input string tag, input logic exp);
        checks++;
        if (valid !== exp) begin
            failures++;
            $display("FAIL %s: valid=%b expected %b", tag, valid, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if (a !== 4'd0 || b !== 4'd0 || op !== 3'd0 || valid !== 1'b0 || stage !== 2'd0) begin
            failures++;
            $display("FAIL %s: got a=%0d b=%0d op=%0d valid=%b stage=%0d, expected all zero",
                     tag, a, b, op, valid, stage);
        end
    endtask

    // Press from WAIT_OP into SHOW and check the valid rule in force.
    task automatic press_op_and_check_valid(input logic [3:0] swv, input string tag);
        int v0;
        int v1;
        v0 = valid_cycles;
        press(swv);
        v1 = valid_cycles;
`ifdef ALU_LOADER_VALID_HOLD_EN
        check_valid({tag, "_hold"}, 1'b1);
`else
        checks++;
        if (v1 - v0 != 1) begin
            failures++;
            $display("FAIL %s_pulse_width: valid high %0d cycles, expected 1", tag, v1 - v0);
        end
        check_valid({tag, "_after"}, 1'b0);
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sw = 4'd0; btn = 1'b0;
        valid_cycles = 0;
        model_reset();
        #1;
        check_zero_outputs("reset_initial");
        idle(3);
        rst_n = 1'b1;
        idle(2);
        check_zero_outputs("reset_released");
    endtask

    task automatic test_full_sequence();
        press(4'd3);
        check_regs("seq_a");
        press(4'd9);
        check_regs("seq_b");
        press_op_and_check_valid(4'd1, "seq_op");
        check_regs("seq_show");
    endtask

    task automatic test_show_exit();
        press(4'd7);
        check_regs("show_exit");
        check_valid("show_exit_valid", 1'b0);
    endtask

    task automatic test_bounce();
        @(negedge clk);
        sw = 4'd6;
        idle(3);
        btn = 1'b1; idle(2);
        btn = 1'b0; idle(1);
        btn = 1'b1; idle(2);
        btn = 1'b0; idle(DB + 8);
        check_regs("bounce_no_change");
        btn = 1'b1; idle(10);
        btn = 1'b0; idle(DB + 6);
        model_press(6);
        check_regs("bounce_one_advance");
    endtask

    task automatic test_held();
        @(negedge clk);
        sw = 4'd12;
        idle(3);
        btn = 1'b1; idle(200);
        btn = 1'b0; idle(DB + 6);
        model_press(12);
        check_regs("held_one_advance");
    endtask

    task automatic test_sw_noise();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sw = (i % 2 == 0) ? 4'hF : 4'h0;
        end
        idle(4);
        check_regs("sw_noise_b_hold");
    endtask

    task automatic test_random_sequences();
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] ro;
        for (int k = 0; k < 4; k++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            ro = 4'($urandom_range(0, 15));
            press(ra);
            check_regs("rand_a");
            press(rb);
            check_regs("rand_b");
            press_op_and_check_valid(ro, "rand_op");
            check_regs("rand_show");
            press(4'($urandom_range(0, 15)));
            check_regs("rand_back");
        end
    endtask

    task automatic test_async_reset_mid();
        press(4'd5);
        check_regs("mid_a_loaded");
        // Assert reset between edges and look before any further edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_zero_outputs("mid_reset_async");
        // Button already high when reset is released counts as one press.
        sw  = 4'd10;
        btn = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(DB + 10);
        btn = 1'b0;
        idle(DB + 6);
        model_press(10);
        check_regs("reset_release_btn_high");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_full_sequence();
        test_show_exit();
        test_bounce();
        test_sw_noise();
        test_held();
        press(4'd2);
        check_regs("after_held");
        press(4'd0);
        check_regs("back_to_wait_a");
        test_random_sequences();
        test_async_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
